// File: rtl/dist_pkg.sv
// Shared types and default parameters for the distance moving-average filter.
// Optional outlier rejection in dist_filter is enabled by DIST_FILTER_OUTLIER_EN.
package dist_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_LOG2_DEPTH = 3;
  localparam int DEF_NEAR_ON    = 20;
  localparam int DEF_NEAR_OFF   = 30;
  localparam int DEF_MAX_CM     = 400;

  // Running sum of 2^log2_depth samples of `width` bits can never overflow this.
  function automatic int sum_width(input int width, input int log2_depth);
    return width + log2_depth;
  endfunction

  localparam int DEF_SUM_W = sum_width(DEF_WIDTH, DEF_LOG2_DEPTH);

endpackage

// File: rtl/dist_ring_buf.sv
// Sample window storage: one register per slot, a wrapping write pointer, and a
// combinational read of the slot about to be overwritten (the oldest sample).
module dist_ring_buf #(
  parameter int WIDTH      = 10,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      oldest,
  output logic [LOG2_DEPTH-1:0] wr_ptr
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [LOG2_DEPTH-1:0]        wr_reg;
  logic [DEPTH-1:0][WIDTH-1:0]  entries;

  // Pointer width equals log2(depth), so the increment wraps on its own.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_reg <= '0;
    end else if (wr_en) begin
      wr_reg <= wr_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_reg == LOG2_DEPTH'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign oldest = entries[wr_reg];
  assign wr_ptr = wr_reg;

endmodule

// File: rtl/dist_filter.sv
// Moving average of ranging samples with a hysteretic near-obstacle flag.
// Define DIST_FILTER_OUTLIER_EN to reject zero / out-of-range samples and count them.
module dist_filter
  import dist_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int NEAR_ON    = DEF_NEAR_ON,
  parameter int NEAR_OFF   = DEF_NEAR_OFF,
  parameter int MAX_CM     = DEF_MAX_CM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dist_in,
  input  logic             dist_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             near,
  output logic [7:0]       reject_cnt
);

  localparam int SUM_W = sum_width(WIDTH, LOG2_DEPTH);
  localparam int DEPTH = 1 << LOG2_DEPTH;

`ifdef DIST_FILTER_OUTLIER_EN
  localparam bit OUTLIER_EN = 1'b1;
`else
  localparam bit OUTLIER_EN = 1'b0;
`endif

  fill_state_t           state_reg;
  logic [SUM_W-1:0]      sum_reg;
  logic [SUM_W-1:0]      sum_next;
  logic                  pend_reg;
  logic [WIDTH-1:0]      avg_reg;
  logic                  avg_valid_reg;
  logic                  near_reg;

  logic                  outlier;
  logic                  accept;
  logic                  last_fill;
  logic [WIDTH-1:0]      oldest;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [WIDTH-1:0]      avg_next;

  assign outlier   = OUTLIER_EN && ((dist_in == '0) || (int'(dist_in) > MAX_CM));
  assign accept    = dist_valid && !flush && !outlier;
  // The write pointer doubles as the fill count: it only advances on accept from 0.
  assign last_fill = (wr_ptr == LOG2_DEPTH'(DEPTH - 1));
  assign avg_next  = sum_reg[SUM_W-1:LOG2_DEPTH];

  always_comb begin
    sum_next = sum_reg + SUM_W'(dist_in);
    if (state_reg == ST_RUN) begin
      sum_next = sum_reg - SUM_W'(oldest) + SUM_W'(dist_in);
    end
  end

  dist_ring_buf #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .wr_en   (accept),
    .wr_data (dist_in),
    .oldest  (oldest),
    .wr_ptr  (wr_ptr)
  );

  // pend_reg marks an average computed at this edge, published on the next one;
  // a flush on that next edge drops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_FILL;
      sum_reg       <= '0;
      pend_reg      <= 1'b0;
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
      near_reg      <= 1'b0;
    end else begin
      avg_valid_reg <= 1'b0;
      pend_reg      <= 1'b0;
      if (flush) begin
        state_reg <= ST_FILL;
        sum_reg   <= '0;
      end else begin
        if (pend_reg) begin
          avg_valid_reg <= 1'b1;
          avg_reg       <= avg_next;
          if (int'(avg_next) <= NEAR_ON) begin
            near_reg <= 1'b1;
          end else if (int'(avg_next) >= NEAR_OFF) begin
            near_reg <= 1'b0;
          end
        end
        if (accept) begin
          sum_reg  <= sum_next;
          pend_reg <= (state_reg == ST_RUN) || last_fill;
          if ((state_reg == ST_FILL) && last_fill) begin
            state_reg <= ST_RUN;
          end
        end
      end
    end
  end

`ifdef DIST_FILTER_OUTLIER_EN
  logic       reject;
  logic [7:0] reject_reg;

  assign reject = dist_valid && !flush && outlier;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reject_reg <= '0;
    end else if (reject && (reject_reg != 8'hFF)) begin
      reject_reg <= reject_reg + 8'd1;
    end
  end

  assign reject_cnt = reject_reg;
`else
  assign reject_cnt = '0;
`endif

  assign avg_out   = avg_reg;
  assign avg_valid = avg_valid_reg;
  assign near      = near_reg;

endmodule

// File: tb/tb_dist_filter.sv
// Directed, table-driven bench for dist_filter (default parameters); honours
// DIST_FILTER_OUTLIER_EN so the same bench covers both builds.
module tb_dist_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] dist_in = '0;
  logic       dist_valid = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] avg_out;
  logic       avg_valid;
  logic       near;
  logic [7:0] reject_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dist_filter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .flush      (flush),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .near       (near),
    .reject_cnt (reject_cnt)
  );

  // Expected outputs are those seen just after the edge that samples the row's inputs.
  typedef struct {
    logic       v;
    logic       f;
    logic [9:0] d;
    logic       ev;
    logic [9:0] ea;
    logic       en;
    logic [7:0] er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic f, input logic [9:0] d,
                     input logic ev, input logic [9:0] ea, input logic en,
                     input logic [7:0] er);
    vec_t x;
    x.v = v; x.f = f; x.d = d; x.ev = ev; x.ea = ea; x.en = en; x.er = er;
    vecs.push_back(x);
  endtask

  // flush, fill with x, then one idle cycle that publishes the new average
  task automatic add_window(input logic [9:0] x, input logic [9:0] prev_avg,
                            input logic prev_near, input logic new_near);
    add(1'b0, 1'b1, 10'd0, 1'b0, prev_avg, prev_near, 8'd0);
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, x, 1'b0, prev_avg, prev_near, 8'd0);
    add(1'b0, 1'b0, 10'd0, 1'b1, x, new_near, 8'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic f, input logic [9:0] d);
    dist_valid = v;
    flush      = f;
    dist_in    = d;
    @(posedge clk);
    #1;
    $display("txn valid=%0b flush=%0b din=%0d -> avg_valid=%0b avg_out=%0d near=%0b reject_cnt=%0d",
             v, f, d, avg_valid, avg_out, near, reject_cnt);
  endtask

  initial begin
    // fill with 100; the 8th sample's average appears one edge later
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 10'd100, 1'b0, 10'd0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd180, 1'b1, 10'd100, 1'b0, 8'd0);
    add(1'b0, 1'b0, 10'd0,   1'b1, 10'd110, 1'b0, 8'd0);
    add(1'b0, 1'b0, 10'd0,   1'b0, 10'd110, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd180, 1'b0, 10'd110, 1'b0, 8'd0);
    for (int k = 1; k <= 6; k++)
      add(1'b1, 1'b0, 10'd180, 1'b1, 10'(110 + 10 * k), 1'b0, 8'd0);
    add(1'b0, 1'b0, 10'd0, 1'b1, 10'd180, 1'b0, 8'd0);
    add(1'b0, 1'b0, 10'd0, 1'b0, 10'd180, 1'b0, 8'd0);

    // hysteresis: windows of 40, 20, 25, 30 -> near 0, 1, 1, 0
    add_window(10'd40, 10'd180, 1'b0, 1'b0);
    add_window(10'd20, 10'd40,  1'b0, 1'b1);
    add_window(10'd25, 10'd20,  1'b1, 1'b1);
    add_window(10'd30, 10'd25,  1'b1, 1'b0);

    // flush with a strobe in RUN: sample dropped, so 7 more strobes leave FILL pending
    add(1'b1, 1'b1, 10'd5, 1'b0, 10'd30, 1'b0, 8'd0);
    for (int k = 0; k < 7; k++) add(1'b1, 1'b0, 10'd50, 1'b0, 10'd30, 1'b0, 8'd0);
    add(1'b0, 1'b0, 10'd0,  1'b0, 10'd30, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd50, 1'b0, 10'd30, 1'b0, 8'd0);
    // back-to-back strobes of 10 -> one avg_valid per cycle
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd50, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd45, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd40, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd35, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd30, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd25, 1'b0, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd20, 1'b1, 8'd0);
    add(1'b1, 1'b0, 10'd10, 1'b1, 10'd15, 1'b1, 8'd0);
    add(1'b0, 1'b0, 10'd0,  1'b1, 10'd10, 1'b1, 8'd0);
    add(1'b0, 1'b0, 10'd0,  1'b0, 10'd10, 1'b1, 8'd0);

    // outlier candidates 0 and 500
`ifdef DIST_FILTER_OUTLIER_EN
    add(1'b1, 1'b0, 10'd0,   1'b0, 10'd10, 1'b1, 8'd1);
    add(1'b1, 1'b0, 10'd500, 1'b0, 10'd10, 1'b1, 8'd2);
    add(1'b0, 1'b0, 10'd0,   1'b0, 10'd10, 1'b1, 8'd2);
    add(1'b0, 1'b0, 10'd0,   1'b0, 10'd10, 1'b1, 8'd2);
`else
    add(1'b1, 1'b0, 10'd0,   1'b0, 10'd10, 1'b1, 8'd0);
    add(1'b1, 1'b0, 10'd500, 1'b1, 10'd8,  1'b1, 8'd0);
    add(1'b0, 1'b0, 10'd0,   1'b1, 10'd70, 1'b0, 8'd0);
    add(1'b0, 1'b0, 10'd0,   1'b0, 10'd70, 1'b0, 8'd0);
`endif

    // reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.avg_out",    32'(avg_out),    32'd0);
    chk("reset.avg_valid",  32'(avg_valid),  32'd0);
    chk("reset.near",       32'(near),       32'd0);
    chk("reset.reject_cnt", 32'(reject_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].f, vecs[i].d);
      chk($sformatf("vec%0d.avg_valid", i),  32'(avg_valid),  32'(vecs[i].ev));
      chk($sformatf("vec%0d.avg_out", i),    32'(avg_out),    32'(vecs[i].ea));
      chk($sformatf("vec%0d.near", i),       32'(near),       32'(vecs[i].en));
      chk($sformatf("vec%0d.reject_cnt", i), 32'(reject_cnt), 32'(vecs[i].er));
    end

    // one-cycle reset mid-RUN with an average in flight
    step(1'b1, 1'b0, 10'd200);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 10'd0);
    chk("midrst.avg_out",    32'(avg_out),    32'd0);
    chk("midrst.avg_valid",  32'(avg_valid),  32'd0);
    chk("midrst.near",       32'(near),       32'd0);
    chk("midrst.reject_cnt", 32'(reject_cnt), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 10'd8);
      chk($sformatf("refill%0d.avg_valid", k), 32'(avg_valid), 32'd0);
    end
    step(1'b0, 1'b0, 10'd0);
    chk("refill.avg_valid", 32'(avg_valid), 32'd1);
    chk("refill.avg_out",   32'(avg_out),   32'd8);
    chk("refill.near",      32'(near),      32'd1);
    step(1'b0, 1'b0, 10'd0);
    chk("refill.pulse_end", 32'(avg_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist_filter.md
# dist_filter

Downstream conditioning stage for the ultrasonic ranging block in the HelioSmart tracker. Takes the raw 10-bit distance samples (cm) and a one-cycle sample strobe, and keeps a moving average over the last 2^LOG2_DEPTH accepted samples. It also drives a hysteretic `near` obstacle flag that the tracker control logic uses to inhibit panel motion.

## Interface
- `WIDTH`, 10: distance sample width, cm.
- `LOG2_DEPTH`, 3: log2 of averaging window; window depth is 8 samples.
- `NEAR_ON`, 20: `near` asserts when the average is at or below this value (cm).
- `NEAR_OFF`, 30: `near` deasserts when the average is at or above this value (cm). Must exceed `NEAR_ON`.
- `MAX_CM`, 400: largest plausible sample, used only by outlier rejection.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dist_in`  in  WIDTH  raw distance from the ranging block.
- `dist_valid`  in  1  one-cycle strobe; `dist_in` is sampled when high.
- `flush`  in  1  synchronous clear of the window without a full reset.
- `avg_out`  out  WIDTH  averaged distance.
- `avg_valid`  out  1  one-cycle pulse when `avg_out` updates.
- `near`  out  1  hysteretic proximity flag.
- `reject_cnt`  out  8  saturating count of rejected samples.

## Operation
- **State machine: FILL → RUN.**
  - Reset and `flush` enter FILL with write pointer 0, running sum 0 and fill count 0.
  - FILL: each accepted sample is written to `buf[wr]`; `sum += dist_in`. Nothing is subtracted and `avg_valid` stays low. The transition to RUN occurs on the 8th accepted sample, and that sample produces the first `avg_valid`.
  - RUN: each accepted sample does `sum <= sum - buf[wr] + dist_in` and `buf[wr] <= dist_in`.
  - The write pointer wraps modulo depth in both states.
- **Arithmetic.**
  - `sum` is WIDTH+LOG2_DEPTH bits wide (13 by default); overflow is impossible.
  - `avg_out = sum >> LOG2_DEPTH`, truncating.
- **`near` hysteresis.** Evaluated only on the edge that loads a new `avg_out`, using the value being loaded:
  - if the value is ≤ `NEAR_ON`, set `near`;
  - else if the value is ≥ `NEAR_OFF`, clear `near`;
  - otherwise hold.
- **`flush`.**
  - Takes priority over `dist_valid` in the same cycle; that sample is dropped.
  - `avg_out` and `near` hold their last values; `reject_cnt` is unaffected.
- **Reset.** Reset mid-operation discards the window; nothing is retained.

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `near`=0, `reject_cnt`=0, state FILL, `sum`=0, wr=0.
- Latency: sample accepted at edge E (sum and buffer updated at E); `avg_out`, `avg_valid` and `near` update at E+1.
- `avg_valid` is high for exactly one cycle per accepted RUN-state sample.
- Back-to-back strobes (`dist_valid` high on consecutive cycles) are each accepted, one sample per cycle; the block must sustain one sample per cycle.
- `flush` or `rst_n` asserted at edge E+1 while a pending average is in flight suppresses that `avg_valid`.

## Configuration
- `DIST_FILTER_OUTLIER_EN` defined:
  - A strobed sample with `dist_in`==0 or `dist_in` > `MAX_CM` is rejected.
  - A rejected sample is not written, does not advance the pointer or fill count, and produces no `avg_valid`.
  - `reject_cnt` increments and saturates at 255.
- `DIST_FILTER_OUTLIER_EN` undefined: every strobed sample is accepted, and `reject_cnt` is tied to 0.

## Structure
- Package `dist_pkg`:
  - FILL/RUN state enum;
  - default `WIDTH`, `LOG2_DEPTH`, `NEAR_ON`, `NEAR_OFF`, `MAX_CM`;
  - derived sum width constant.
- Sub-module `dist_ring_buf`: depth-parameterised register array with write pointer and wrap. It is written on accept and supplies the oldest entry combinationally for subtraction.
- Top level holds the FSM, running sum, output registers, hysteresis and reject counter.

## Test plan
- Reset, then 8 strobes of 100 → no `avg_valid` for the first 7 samples. One cycle after the 8th: `avg_valid`=1, `avg_out`=100, `near`=0.
- Window filled with 100, then a strobe of 180 → `avg_out`=110; a further 7 strobes of 180 → `avg_out`=180.
- Windows averaging 40, then 20, then 25, then 30 → `near` sequence 0, 1, 1, 0.
- With `DIST_FILTER_OUTLIER_EN`, strobes of 0 and 500 → `reject_cnt`=2, no `avg_valid`, `avg_out` unchanged. Without the macro, both samples are accepted and `reject_cnt`=0.
- In RUN, `flush` and `dist_valid` in the same cycle → sample dropped, state FILL, and no `avg_valid` until 8 new samples; back-to-back strobes then yield consecutive `avg_valid` pulses.
- `rst_n` low for one cycle mid-RUN → all outputs 0 on the next edge, and FILL behaviour restarts.
